// File: rtl/fnd_pkg.sv
// Shared types, constants and helper functions for the FND scan scheduler.
// The segment table and the shift-add-3 adjust step are used by the top
// level and by the sequential binary-to-BCD converter.
package fnd_pkg;

    typedef logic [3:0] bcd_digit_t;

    typedef enum logic {
        S_SHOW  = 1'b0,
        S_BLANK = 1'b1
    } scan_state_t;

    localparam logic [7:0] SEG_OFF  = 8'hFF;
    localparam logic [3:0] COMM_OFF = 4'hF;

    // Active-low segment codes for a common-anode digit, dp (bit 7) kept off.
    // Entry 0 sits in the low byte.
    localparam logic [9:0][7:0] SEG_TABLE = {
        8'h90, 8'h80, 8'hF8, 8'h82, 8'h92,
        8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
    };

    // Codes above 9 never occur; they fall back to a dark digit.
    function automatic logic [7:0] seg_decode(input bcd_digit_t digit);
        logic [7:0] code;
        code = SEG_OFF;
        if (digit <= 4'd9) begin
            code = SEG_TABLE[digit];
        end
        return code;
    endfunction

    // One double-dabble correction: every BCD nibble of 5 or more gets +3
    // so that the following left shift carries correctly into the next digit.
    function automatic logic [11:0] dabble_adjust(input logic [11:0] bcd);
        logic [11:0] adj;
        adj = bcd;
        for (int i = 0; i < 3; i++) begin
            if (bcd[i*4 +: 4] >= 4'd5) begin
                adj[i*4 +: 4] = bcd[i*4 +: 4] + 4'd3;
            end
        end
        return adj;
    endfunction

endpackage

// File: rtl/fnd_scan_scheduler_if.sv
// Value/strobe side and FND pin side of the scan scheduler, bundled.
// master drives the value and load strobe, slave is the scheduler itself.
interface fnd_scan_scheduler_if;

    logic [8:0] i_value;
    logic       i_load;
    logic       o_busy;
    logic       o_frame;
    logic [1:0] o_seg_sel;
    logic [3:0] o_seg_comm;
    logic [7:0] o_seg;

    modport master (
        output i_value,
        output i_load,
        input  o_busy,
        input  o_frame,
        input  o_seg_sel,
        input  o_seg_comm,
        input  o_seg
    );

    modport slave (
        input  i_value,
        input  i_load,
        output o_busy,
        output o_frame,
        output o_seg_sel,
        output o_seg_comm,
        output o_seg
    );

endinterface

// File: rtl/bin2bcd_seq.sv
// Sequential 9-bit binary to 3-digit BCD converter (shift-add-3).
// A start loads the operand and runs 9 iterations, one per clock. done is
// high during the final iteration, so the result register and the busy drop
// update on the same edge. A start on that edge restarts immediately and
// busy stays high.
module bin2bcd_seq
    import fnd_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [8:0]  value,
    output logic        busy,
    output logic        done,
    output logic [11:0] bcd
);

    logic [8:0]  bin_sr;
    logic [11:0] work;
    logic [3:0]  steps_left;
    logic        busy_r;
    logic [11:0] result;
    logic [20:0] shifted;

    assign shifted = {dabble_adjust(work), bin_sr} << 1;
    assign done    = busy_r && (steps_left == 4'd1);
    assign busy    = busy_r;
    assign bcd     = result;

    // Iteration engine plus the result register that the display commits from.
    always_ff @(posedge clk) begin
        if (reset) begin
            bin_sr     <= '0;
            work       <= '0;
            steps_left <= '0;
            busy_r     <= 1'b0;
            result     <= '0;
        end else begin
            if (done) begin
                result <= shifted[20:9];
            end
            if (start) begin
                bin_sr     <= value;
                work       <= '0;
                steps_left <= 4'd9;
                busy_r     <= 1'b1;
            end else if (busy_r) begin
                bin_sr     <= shifted[8:0];
                work       <= shifted[20:9];
                steps_left <= steps_left - 4'd1;
                if (done) begin
                    busy_r <= 1'b0;
                end
            end
        end
    end

endmodule

// File: rtl/fnd_scan_scheduler.sv
// Four-digit common-anode FND scan scheduler.
// Latches a 9-bit value, converts it to BCD in the background, and scans the
// digits with a DIV-clock dwell and a BLANK_CYC anti-ghost gap. New results
// are committed only at the frame boundary so a frame never tears.
// Optional build macro: FND_LZB_EN enables leading-zero blanking.
module fnd_scan_scheduler
    import fnd_pkg::*;
#(
    parameter int CLK_HZ    = 100_000_000,
    parameter int SCAN_HZ   = 1000,
    parameter int BLANK_CYC = 16
) (
    input logic                 clk,
    input logic                 reset,
    fnd_scan_scheduler_if.slave bus
);

    localparam int DIV = CLK_HZ / SCAN_HZ;
    localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int BW  = (BLANK_CYC > 1) ? $clog2(BLANK_CYC) : 1;
    localparam logic [PW-1:0] DIV_LAST   = PW'(DIV - 1);
    localparam logic [BW-1:0] BLANK_LAST = BW'(BLANK_CYC - 1);

    logic        conv_start;
    logic        conv_busy;
    logic        conv_done;
    logic [8:0]  conv_value;
    logic [11:0] shadow_bcd;
    logic        pend_valid;
    logic [8:0]  pend_value;

    scan_state_t state, state_n;
    logic [PW-1:0] pre_cnt, pre_n;
    logic [BW-1:0] blk_cnt, blk_n;
    logic [1:0]    sel, sel_n;
    logic [11:0]   disp, disp_n;
    logic          wrap;
    logic [3:0]    comm_n, comm_r;
    logic [7:0]    seg_n, seg_r;
    logic          frame_r;
    bcd_digit_t    digit;
    logic          suppress;

    // A load while idle starts at once; at the done edge the newest of the
    // pending value and a coincident load restarts the converter back-to-back.
    assign conv_start = (bus.i_load && !conv_busy) ||
                        (conv_done && (pend_valid || bus.i_load));
    assign conv_value = bus.i_load ? bus.i_value : pend_value;

    // The converter's result register doubles as the shadow BCD.
    bin2bcd_seq u_bin2bcd (
        .clk   (clk),
        .reset (reset),
        .start (conv_start),
        .value (conv_value),
        .busy  (conv_busy),
        .done  (conv_done),
        .bcd   (shadow_bcd)
    );

    // One-deep pending slot: loads arriving while busy overwrite it.
    always_ff @(posedge clk) begin
        if (reset) begin
            pend_valid <= 1'b0;
            pend_value <= '0;
        end else if (conv_done && (pend_valid || bus.i_load)) begin
            pend_valid <= 1'b0;
        end else if (bus.i_load && conv_busy) begin
            pend_valid <= 1'b1;
            pend_value <= bus.i_value;
        end
    end

    // Scan state, counters, committed display value and registered pins.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= S_SHOW;
            pre_cnt <= '0;
            blk_cnt <= '0;
            sel     <= 2'd0;
            disp    <= '0;
            comm_r  <= COMM_OFF;
            seg_r   <= SEG_OFF;
            frame_r <= 1'b0;
        end else begin
            state   <= state_n;
            pre_cnt <= pre_n;
            blk_cnt <= blk_n;
            sel     <= sel_n;
            disp    <= disp_n;
            comm_r  <= comm_n;
            seg_r   <= seg_n;
            frame_r <= wrap;
        end
    end

    // Dwell in S_SHOW for DIV clocks, then dark for BLANK_CYC clocks before
    // advancing the digit; the 3 -> 0 advance is the frame commit point.
    always_comb begin
        state_n = state;
        pre_n   = pre_cnt;
        blk_n   = blk_cnt;
        sel_n   = sel;
        wrap    = 1'b0;
        case (state)
            S_SHOW: begin
                if (pre_cnt == DIV_LAST) begin
                    state_n = S_BLANK;
                    pre_n   = '0;
                    blk_n   = '0;
                end else begin
                    pre_n = pre_cnt + 1'b1;
                end
            end
            S_BLANK: begin
                if (blk_cnt == BLANK_LAST) begin
                    state_n = S_SHOW;
                    blk_n   = '0;
                    sel_n   = sel + 2'd1;
                    wrap    = (sel == 2'd3);
                end else begin
                    blk_n = blk_cnt + 1'b1;
                end
            end
            default: begin
                state_n = S_SHOW;
            end
        endcase
        disp_n = wrap ? shadow_bcd : disp;
    end

    // Pin values for the next cycle, derived from the next state so the
    // registered pins move on the same edge as the state and digit index.
    always_comb begin
        case (sel_n)
            2'd0:    digit = disp_n[3:0];
            2'd1:    digit = disp_n[7:4];
            2'd2:    digit = disp_n[11:8];
            default: digit = 4'd0;
        endcase
`ifdef FND_LZB_EN
        case (sel_n)
            2'd3:    suppress = 1'b1;
            2'd2:    suppress = (disp_n[11:8] == 4'd0);
            2'd1:    suppress = (disp_n[11:8] == 4'd0) && (disp_n[7:4] == 4'd0);
            default: suppress = 1'b0;
        endcase
`else
        suppress = 1'b0;
`endif
        comm_n = COMM_OFF;
        seg_n  = SEG_OFF;
        if ((state_n == S_SHOW) && !suppress) begin
            comm_n = ~(4'b0001 << sel_n);
            seg_n  = seg_decode(digit);
        end
    end

    assign bus.o_busy     = conv_busy;
    assign bus.o_frame    = frame_r;
    assign bus.o_seg_sel  = sel;
    assign bus.o_seg_comm = comm_r;
    assign bus.o_seg      = seg_r;

endmodule

// File: tb/tb_fnd_scan_scheduler.sv
// Self-checking bench for fnd_scan_scheduler (DIV = 10, BLANK_CYC = 2).
// Each load pushes the expected digit codes and the cycle its conversion
// lands onto a scoreboard; entries are popped at frame boundaries and every
// cycle the pins are compared against a cycle-count model of the scan.
module tb_fnd_scan_scheduler;

    localparam int DIV_T   = 10;
    localparam int BLANK_T = 2;
    localparam int SLOT    = DIV_T + BLANK_T;
    localparam int FRAME   = 4 * SLOT;

    typedef struct {
        int              ready;
        logic [3:0][7:0] seg;
        logic [3:0]      lit;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    fnd_scan_scheduler_if bus ();

    fnd_scan_scheduler #(
        .CLK_HZ    (1000),
        .SCAN_HZ   (100),
        .BLANK_CYC (BLANK_T)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int   cyc;
    int   checks;
    int   fails;
    bit   mon_en;
    exp_t sb[$];
    exp_t cur;
    int   last_done;
    int   busy_lo;
    int   busy_hi;

    function automatic logic [7:0] segCode(input int d);
        case (d)
            0: return 8'hC0;
            1: return 8'hF9;
            2: return 8'hA4;
            3: return 8'hB0;
            4: return 8'h99;
            5: return 8'h92;
            6: return 8'h82;
            7: return 8'hF8;
            8: return 8'h80;
            9: return 8'h90;
            default: return 8'hFF;
        endcase
    endfunction

    function automatic exp_t makeExpect(input int v);
        exp_t x;
        int h, t, o;
        h = v / 100;
        t = (v / 10) % 10;
        o = v % 10;
        x.ready  = 0;
        x.seg[0] = segCode(o);
        x.seg[1] = segCode(t);
        x.seg[2] = segCode(h);
        x.seg[3] = segCode(0);
`ifdef FND_LZB_EN
        x.lit = {1'b0, h != 0, (h != 0) || (t != 0), 1'b1};
`else
        x.lit = 4'b1111;
`endif
        return x;
    endfunction

    task automatic checkOutput(input string tag, input logic [7:0] observed,
                               input logic [7:0] expected);
        checks++;
        if (observed !== expected) begin
            fails++;
            $display("[TB] FAIL %s at cycle %0d: observed %h required %h",
                     tag, cyc, observed, expected);
        end
    endtask

    // One clock: advance the model at the rising edge, compare at the falling edge.
    task automatic stepClock();
        int         slot, phase;
        logic [3:0] exp_comm;
        logic [7:0] exp_seg;
        bit         exp_frame, exp_busy;
        @(posedge clk);
        if (reset) begin
            cyc       = 0;
            sb.delete();
            cur       = makeExpect(0);
            last_done = -100;
            busy_lo   = 0;
            busy_hi   = -1;
        end else begin
            cyc++;
        end
        @(negedge clk);
        if (mon_en) begin
            slot      = (cyc / SLOT) % 4;
            phase     = cyc % SLOT;
            exp_frame = (cyc > 0) && (cyc % FRAME == 0);
            if (exp_frame) begin
                while (sb.size() > 0 && sb[0].ready < cyc) begin
                    cur = sb.pop_front();
                end
            end
            exp_busy = (cyc >= busy_lo) && (cyc <= busy_hi);
            exp_comm = 4'hF;
            exp_seg  = 8'hFF;
            if ((cyc != 0) && (phase < DIV_T) && cur.lit[slot]) begin
                exp_comm[slot] = 1'b0;
                exp_seg        = cur.seg[slot];
            end
            checkOutput("comm",  {4'h0, bus.o_seg_comm}, {4'h0, exp_comm});
            checkOutput("seg",   bus.o_seg, exp_seg);
            checkOutput("sel",   {6'h0, bus.o_seg_sel}, 8'(slot));
            checkOutput("frame", {7'h0, bus.o_frame}, {7'h0, exp_frame});
            checkOutput("busy",  {7'h0, bus.o_busy}, {7'h0, exp_busy});
        end
    endtask

    task automatic runCycles(input int n);
        for (int i = 0; i < n; i++) stepClock();
    endtask

    task automatic waitPhase(input int modulus, input int target);
        for (int i = 0; i < modulus; i++) begin
            if (cyc % modulus == target) break;
            stepClock();
        end
    endtask

    // Drive a one-cycle load and enqueue what the display must show once
    // the conversion has landed; a load that finds the converter busy waits
    // for the running conversion and replaces any earlier waiting value.
    task automatic applyStimulus(input int v);
        int   e, start, done;
        exp_t x;
        e     = cyc + 1;
        start = (e > last_done) ? e : last_done;
        done  = start + 9;
        if (start == e) begin
            busy_lo = e;
        end else if (sb.size() > 0 && sb[sb.size()-1].ready == done) begin
            void'(sb.pop_back());
        end
        busy_hi   = done - 1;
        last_done = done;
        x         = makeExpect(v);
        x.ready   = done;
        sb.push_back(x);
        bus.i_value = 9'(v);
        bus.i_load  = 1'b1;
        stepClock();
        bus.i_load  = 1'b0;
    endtask

    initial begin
        reset       = 1'b1;
        bus.i_load  = 1'b0;
        bus.i_value = '0;
        mon_en      = 1'b0;
        checks      = 0;
        fails       = 0;
        cyc         = 0;
        cur         = makeExpect(0);
        last_done   = -100;
        busy_lo     = 0;
        busy_hi     = -1;

        // Reset held 3 clocks, then two idle frames showing 0.
        stepClock();
        mon_en = 1'b1;
        runCycles(2);
        reset = 1'b0;
        runCycles(2 * FRAME);

        // Full-scale value.
        applyStimulus(511);
        runCycles(2 * FRAME + 10);

        // Back-to-back loads within one frame: only the later one is shown.
        waitPhase(FRAME, 1);
        applyStimulus(123);
        stepClock();
        applyStimulus(7);
        runCycles(2 * FRAME);

        // Conversion landing on the wrap edge shows up one frame later.
        waitPhase(FRAME, 38);
        applyStimulus(42);
        runCycles(3 * FRAME);

        // Reset during a conversion with a pending load, inside the blank gap.
        waitPhase(SLOT, 5);
        applyStimulus(300);
        applyStimulus(200);
        waitPhase(SLOT, 10);
        reset = 1'b1;
        runCycles(2);
        reset = 1'b0;
        runCycles(2 * FRAME);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/fnd_scan_scheduler.md
Name: fnd_scan_scheduler

Overview:
- Sequences a 4-digit common-anode 7-segment display from a 9-bit binary value (0..511).
- Latches the value on a load strobe and converts it to BCD sequentially (shift-add-3).
- Time-multiplexes the digits with a programmable scan rate and an anti-ghost blank gap.
- Sits between the adder result and the board FND pins. It owns digit select, which was previously a free input.

Parameters:
- CLK_HZ, 100_000_000, input clock frequency.
- SCAN_HZ, 1000, per-digit dwell rate. DIV = CLK_HZ/SCAN_HZ clocks per digit; DIV must be >= 2.
- BLANK_CYC, 16, clocks of all-digits-off between digit switches; must be >= 1.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- i_value  in  9  binary value to display
- i_load  in  1  single-cycle strobe; samples i_value
- o_busy  out  1  BCD conversion in progress
- o_frame  out  1  one-cycle pulse at each frame boundary (digit 3 -> 0)
- o_seg_sel  out  2  current digit index (0 = ones)
- o_seg_comm  out  4  digit enables, active-low; 1110 = digit 0
- o_seg  out  8  segments, active-low, bit 7 = dp (always 1)

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high. Nothing else is asynchronous.
- Reset values:
  - o_seg_sel = 0, o_seg_comm = 4'b1111, o_seg = 8'hFF, o_busy = 0, o_frame = 0.
  - Shadow and display BCD registers = 0, prescaler = 0, FSM = S_SHOW.
- Prescaler: counts 0..DIV-1 in S_SHOW only. tick = (count == DIV-1), after which it clears.
- FSM:
  - S_SHOW: o_seg_comm = one-hot-low of o_seg_sel; o_seg = decode of the display digit. On tick go to S_BLANK.
  - S_BLANK: o_seg_comm = 4'b1111, o_seg = 8'hFF for exactly BLANK_CYC clocks. Then o_seg_sel <= o_seg_sel+1 (wraps 3 -> 0) and go to S_SHOW.
  - Hence each digit is lit DIV clocks, and a frame is 4*(DIV+BLANK_CYC) clocks.
- Outputs are registered: o_seg/o_seg_comm change on the same edge as the state/o_seg_sel change.
- Frame commit: on the edge where o_seg_sel wraps 3 -> 0, display BCD <= shadow BCD and o_frame pulses for 1 clock. Display digits never change mid-frame (no tearing).
- Converter (shift-add-3, 9 iterations):
  - i_load while idle: capture i_value and assert o_busy the next clock.
  - Exactly 9 clocks later the shadow register gets {thousands=0, hundreds, tens, ones} and o_busy drops.
  - i_load while busy: value stored in a 1-deep pending register; the latest value wins. A new conversion starts the clock after done, so o_busy stays high.
  - i_load on the same clock as done: treated as pending.
- Commit coincident with converter completion: the commit uses the shadow as it stands before that edge. The new result appears at the next frame.
- Digit decode: 0-9 use standard active-low codes (0 = C0, 1 = F9, 8 = 80, 9 = 90). Codes A-F are unreachable.
- Reset mid-operation: abort conversion, drop pending, clear shadow and display, return to reset values on the next edge.
- Worst-case i_load to visible latency: 2*10 + 4*(DIV+BLANK_CYC) clocks.

Optional Feature:
- Macro: FND_LZB_EN (leading-zero blanking).
- Defined:
  - Digit 3 is always suppressed.
  - Digit 2 is suppressed if hundreds = 0.
  - Digit 1 is suppressed if hundreds = 0 and tens = 0.
  - Digit 0 is never suppressed.
  - A suppressed slot keeps its timing but drives o_seg_comm = 4'b1111, o_seg = 8'hFF.
- Undefined: all four digits are lit, showing zero-padded values (e.g. 0042).

Decomposition:
- Package fnd_pkg:
  - Typedef for the 4-bit BCD digit.
  - Typedef for the FSM state enum {S_SHOW, S_BLANK}.
  - Constant SEG_OFF = 8'hFF, constant COMM_OFF = 4'hF.
  - 10-entry segment code constant table.
- Sub-module bin2bcd_seq: 9-bit sequential double-dabble with start/busy/done and 12-bit BCD out. Pending-load logic stays in the parent.

Test Plan (sim params CLK_HZ=1000, SCAN_HZ=100 -> DIV=10, BLANK_CYC=2):
- Reset held 3 clocks, then released with no load -> comm sequence 1110,1111,1101,1111,1011,1111,0111,1111 with dwell 10/2 clocks, seg=C0 in each lit slot, o_frame every 48 clocks.
- i_load with 9'd511 -> o_busy high 9 clocks; after the next o_frame, digit0 seg=F9, digit1 seg=F9, digit2 seg=92, digit3 seg=C0 (LZB off).
- i_load 9'd123 then i_load 9'd7 two clocks later -> one conversion of 123 completes, 7 converts back-to-back with o_busy continuously high, 123 is never committed if both finish in the same frame, and the display shows 7.
- FND_LZB_EN defined, value 9'd7 -> digit0 seg=F8; digits 1-3 comm=1111 in their slots, which keep 10-clock timing. Value 9'd0 -> only digit0 lit, seg=C0.
- Conversion done on the same edge as wrap 3 -> 0 -> that frame shows the old value and the next frame the new one.
- reset asserted mid-conversion and mid-S_BLANK -> next edge gives all reset values and o_busy=0; the pending load is discarded.
